rf_free_sequencer: RTL and testbench

RF_FREE_SEQUENCER -- requirements
Module: rf_free_sequencer

---
 rtl/rf_free_sequencer_if.sv | 33 +++
 rtl/rf_free_sequencer.sv | 112 +++++++++++
 tb/tb_rf_free_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_free_sequencer_if.sv
// Bundle of allocation, writeback, flush and free signals shared by the free
// sequencer and whatever drives it.
interface rf_free_sequencer_if #(
  parameter int name_width = 2
);
  logic                  ALLOC_E;
  logic [name_width-1:0] ALLOC_NAME;
  logic                  DONE_E_1;
  logic [name_width-1:0] DONE_NAME_1;
  logic                  DONE_E_2;
  logic [name_width-1:0] DONE_NAME_2;
  logic                  FLUSH_E;
  logic [name_width-1:0] FLUSH_NAME;
  logic [name_width-1:0] W_F;
  logic                  WFE;
  logic                  F_READY;
  logic [name_width:0]   COUNT;
  logic                  EMPTY;
  logic                  FULL;
  logic                  ERR;

  modport master (
    output ALLOC_E, ALLOC_NAME, DONE_E_1, DONE_NAME_1, DONE_E_2, DONE_NAME_2,
           FLUSH_E, FLUSH_NAME, F_READY,
    input  W_F, WFE, COUNT, EMPTY, FULL, ERR
  );

  modport slave (
    input  ALLOC_E, ALLOC_NAME, DONE_E_1, DONE_NAME_1, DONE_E_2, DONE_NAME_2,
           FLUSH_E, FLUSH_NAME, F_READY,
    output W_F, WFE, COUNT, EMPTY, FULL, ERR
  );
endinterface

// File: rtl/rf_free_sequencer.sv
// In-order free sequencer for register-file write-queue names: tracks
// allocation order, writeback completion and flushes, then offers the oldest
// completed name for freeing.
module rf_free_sequencer #(
  parameter int name_width = 2,
  parameter int numNames   = 2**name_width
) (
  input  logic                 CLK,
  input  logic                 RST,
  rf_free_sequencer_if.slave   bus
);

  localparam logic [name_width:0] NUM_NAMES_W = (name_width+1)'(numNames);

  logic [name_width-1:0] head_q, head_d, tail_q, tail_d;
  logic [name_width:0]   count_q, count_d;
  logic [numNames-1:0]   valid_q, valid_d, done_q, done_d;
  logic                  err_q, err_d;

  logic                  empty, full, wfe_int, free_fire;
  logic                  flush_ok, alloc_fire, alloc_err;
  logic                  done_ok_1, done_ok_2;
  logic [name_width-1:0] flush_off;
  logic [numNames-1:0]   squash;

  assign empty     = (count_q == '0);
  assign full      = (count_q == NUM_NAMES_W);
  // Reset masks the free request so nothing is freed on the reset edge.
  assign wfe_int   = !RST && !empty && done_q[head_q];
  assign free_fire = wfe_int && bus.F_READY;

  assign flush_ok   = bus.FLUSH_E && valid_q[bus.FLUSH_NAME];
  assign flush_off  = bus.FLUSH_NAME - head_q;
  assign alloc_fire = bus.ALLOC_E && !flush_ok && !full && (bus.ALLOC_NAME == tail_q);
  assign alloc_err  = bus.ALLOC_E && !flush_ok && (full || (bus.ALLOC_NAME != tail_q));
  assign done_ok_1  = bus.DONE_E_1 && valid_q[bus.DONE_NAME_1];
  assign done_ok_2  = bus.DONE_E_2 && valid_q[bus.DONE_NAME_2];

  // Age of a name is its distance from head; anything older-than-tail and
  // farther than the flush name is squashed.
  generate
    for (genvar gi = 0; gi < numNames; gi++) begin : g_squash
      assign squash[gi] = valid_q[gi] && ((name_width'(gi) - head_q) > flush_off);
    end
  endgenerate

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;

    if (done_ok_1) done_d[bus.DONE_NAME_1] = 1'b1;
    if (done_ok_2) done_d[bus.DONE_NAME_2] = 1'b1;

    if (flush_ok) begin
      valid_d = valid_d & ~squash;
      done_d  = done_d & ~squash;
      tail_d  = bus.FLUSH_NAME + 1'b1;
      count_d = {1'b0, flush_off} + (name_width+1)'(1) - (name_width+1)'(free_fire);
    end else begin
      count_d = count_q + (name_width+1)'(alloc_fire) - (name_width+1)'(free_fire);
    end

    if (free_fire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
      head_d          = head_q + 1'b1;
    end

    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
      tail_d          = tail_q + 1'b1;
    end

    if (alloc_err
        || (bus.DONE_E_1 && !valid_q[bus.DONE_NAME_1])
        || (bus.DONE_E_2 && !valid_q[bus.DONE_NAME_2])
        || (bus.FLUSH_E && !valid_q[bus.FLUSH_NAME])) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.W_F   = RST ? '0 : head_q;
  assign bus.WFE   = wfe_int;
  assign bus.COUNT = RST ? '0 : count_q;
  assign bus.EMPTY = RST || empty;
  assign bus.FULL  = !RST && full;
  assign bus.ERR   = !RST && err_q;

endmodule

// File: tb/tb_rf_free_sequencer.sv
// Scoreboard bench for rf_free_sequencer: allocated names are queued in order
// and popped whenever the sequencer offers a free that is accepted.
module tb_rf_free_sequencer;
  localparam int NW = 2;

  logic CLK = 1'b0;
  logic RST;

  rf_free_sequencer_if #(.name_width(NW)) bus ();

  rf_free_sequencer #(.name_width(NW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;
  int unsigned sb_q[$];

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // An accepted free is visible before the edge that performs it.
  always @(negedge CLK) begin
    if (bus.WFE === 1'b1 && bus.F_READY === 1'b1) begin
      if (sb_q.size() == 0) check_val("free_unexpected_qsize", sb_q.size(), 1);
      else                  check_val("free_order", bus.W_F, sb_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic alloc(input int n, input bit accept);
    bus.ALLOC_E    = 1'b1;
    bus.ALLOC_NAME = NW'(n);
    if (accept) sb_q.push_back(n);
    cyc();
    bus.ALLOC_E = 1'b0;
  endtask

  task automatic done1(input int n);
    bus.DONE_E_1    = 1'b1;
    bus.DONE_NAME_1 = NW'(n);
    cyc();
    bus.DONE_E_1 = 1'b0;
  endtask

  task automatic done2(input int a, input int b);
    bus.DONE_E_1    = 1'b1;
    bus.DONE_NAME_1 = NW'(a);
    bus.DONE_E_2    = 1'b1;
    bus.DONE_NAME_2 = NW'(b);
    cyc();
    bus.DONE_E_1 = 1'b0;
    bus.DONE_E_2 = 1'b0;
  endtask

  task automatic flush(input int n);
    bus.FLUSH_E    = 1'b1;
    bus.FLUSH_NAME = NW'(n);
    while (sb_q.size() > 0 && sb_q[$] != n) void'(sb_q.pop_back());
    cyc();
    bus.FLUSH_E  = 1'b0;
    bus.ALLOC_E  = 1'b0;
    bus.DONE_E_2 = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    sb_q.delete();
    cyc();
    RST = 1'b0;
    cyc();
  endtask

  initial begin
    RST             = 1'b1;
    bus.ALLOC_E     = 1'b0;
    bus.ALLOC_NAME  = '0;
    bus.DONE_E_1    = 1'b0;
    bus.DONE_NAME_1 = '0;
    bus.DONE_E_2    = 1'b0;
    bus.DONE_NAME_2 = '0;
    bus.FLUSH_E     = 1'b0;
    bus.FLUSH_NAME  = '0;
    bus.F_READY     = 1'b0;
    cyc();
    cyc();
    check_val("rst_wfe", bus.WFE, 0);
    check_val("rst_count", bus.COUNT, 0);
    check_val("rst_empty", bus.EMPTY, 1);
    check_val("rst_full", bus.FULL, 0);
    check_val("rst_err", bus.ERR, 0);
    RST = 1'b0;
    cyc();
    check_val("post_rst_wf", bus.W_F, 0);
    check_val("post_rst_empty", bus.EMPTY, 1);

    // Out-of-order completion, in-order free
    bus.F_READY = 1'b1;
    for (int i = 0; i < 3; i++) alloc(i, 1'b1);
    check_val("ooo_count", bus.COUNT, 3);
    done1(2);
    check_val("ooo_wfe_blocked", bus.WFE, 0);
    done1(0);
    check_val("ooo_wfe_head", bus.WFE, 1);
    check_val("ooo_wf_head", bus.W_F, 0);
    cyc();
    check_val("ooo_wf_after_free", bus.W_F, 1);
    check_val("ooo_wfe_wait", bus.WFE, 0);
    check_val("ooo_count2", bus.COUNT, 2);
    done1(1);
    check_val("ooo_wf1", bus.W_F, 1);
    cyc();
    check_val("ooo_wf2", bus.W_F, 2);
    check_val("ooo_wfe2", bus.WFE, 1);
    cyc();
    check_val("ooo_empty", bus.EMPTY, 1);
    check_val("ooo_err", bus.ERR, 0);

    // Full, refused allocation, wrap
    bus.F_READY = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i, 1'b1);
    check_val("full_flag", bus.FULL, 1);
    check_val("full_count", bus.COUNT, 4);
    alloc(0, 1'b0);
    check_val("full_refused_err", bus.ERR, 1);
    check_val("full_refused_count", bus.COUNT, 4);
    done1(0);
    bus.F_READY = 1'b1;
    cyc();
    bus.F_READY = 1'b0;
    check_val("full_free_count", bus.COUNT, 3);
    alloc(0, 1'b1);
    check_val("wrap_count", bus.COUNT, 4);
    check_val("wrap_full", bus.FULL, 1);

    // Free request holds until F_READY
    done1(1);
    for (int i = 0; i < 3; i++) begin
      check_val("hold_wfe", bus.WFE, 1);
      check_val("hold_wf", bus.W_F, 1);
      cyc();
    end
    bus.F_READY = 1'b1;
    cyc();
    bus.F_READY = 1'b0;
    check_val("hold_wf_next", bus.W_F, 2);
    check_val("hold_count", bus.COUNT, 3);
    check_val("hold_wfe_next", bus.WFE, 0);

    // Flush with a dropped allocation and a squashed writeback
    do_reset();
    for (int i = 0; i < 4; i++) alloc(i, 1'b1);
    bus.ALLOC_E     = 1'b1;
    bus.ALLOC_NAME  = 2'd0;
    bus.DONE_E_2    = 1'b1;
    bus.DONE_NAME_2 = 2'd3;
    flush(1);
    check_val("flush_count", bus.COUNT, 2);
    check_val("flush_full", bus.FULL, 0);
    check_val("flush_err", bus.ERR, 0);
    done1(3);
    check_val("flush_done_squashed_err", bus.ERR, 1);
    alloc(2, 1'b1);
    check_val("flush_tail_count", bus.COUNT, 3);

    // Dual writeback, back-to-back frees
    do_reset();
    bus.F_READY = 1'b1;
    alloc(0, 1'b1);
    alloc(1, 1'b1);
    done2(0, 1);
    check_val("dual_wf0", bus.W_F, 0);
    cyc();
    check_val("dual_wf1", bus.W_F, 1);
    check_val("dual_wfe1", bus.WFE, 1);
    cyc();
    check_val("dual_empty", bus.EMPTY, 1);

    // Reset discards completed names
    bus.F_READY = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) alloc(i, 1'b1);
    done2(0, 1);
    done1(2);
    RST = 1'b1;
    bus.F_READY = 1'b1;
    sb_q.delete();
    cyc();
    RST = 1'b0;
    check_val("midrst_empty", bus.EMPTY, 1);
    check_val("midrst_wfe", bus.WFE, 0);
    check_val("midrst_err", bus.ERR, 0);
    alloc(0, 1'b1);
    check_val("midrst_alloc_count", bus.COUNT, 1);
    check_val("midrst_alloc_err", bus.ERR, 0);
    done1(0);
    check_val("midrst_wf", bus.W_F, 0);
    cyc();
    check_val("midrst_drained", bus.EMPTY, 1);
    check_val("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end
endmodule
